// File: rtl/uart_tx.sv
// Buffered UART transmitter: a small byte FIFO feeding an 8N1 serialiser, LSB first.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data and stop bits (8E1).
module uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_serial,
    output logic             tx_active,
    output logic             tx_done,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
`endif

    // ---------------- byte FIFO ----------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    // Ready depends only on the registered count, so a pop on the same edge
    // never lets a write into a full FIFO.
    assign tx_ready   = (count_reg != CNT_FULL);
    assign fifo_empty = (count_reg == '0);
    assign push       = tx_valid && tx_ready;
    assign fifo_count = count_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // ---------------- serialiser FSM ----------------
    state_t            state_reg,  state_next;
    logic [BAUD_W-1:0] baud_reg,   baud_next;
    logic [2:0]        bit_reg,    bit_next;
    logic [7:0]        shift_reg,  shift_next;
    logic              serial_reg, serial_next;
    logic              active_reg, active_next;
    logic              done_reg,   done_next;
    logic              baud_last;
    logic [2:0]        bit_inc;

    assign baud_last = (baud_reg == '0);
    assign bit_inc   = bit_reg + 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            serial_reg <= 1'b1;
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            baud_reg   <= baud_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            serial_reg <= serial_next;
            active_reg <= active_next;
            done_reg   <= done_next;
        end
    end

    // Outputs are computed for the next state so the line itself is a flop.
    always_comb begin
        state_next  = state_reg;
        baud_next   = baud_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        serial_next = serial_reg;
        active_next = active_reg;
        done_next   = 1'b0;
        pop         = 1'b0;

        case (state_reg)
            S_IDLE: begin
                serial_next = 1'b1;
                active_next = 1'b0;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_next  = mem[rd_ptr_reg];
                    state_next  = S_START;
                    baud_next   = BAUD_LAST;
                    serial_next = 1'b0;
                    active_next = 1'b1;
                end
            end

            S_START: begin
                if (baud_last) begin
                    state_next  = S_DATA;
                    baud_next   = BAUD_LAST;
                    bit_next    = 3'd0;
                    serial_next = shift_reg[0];
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end

            S_DATA: begin
                if (baud_last) begin
                    baud_next = BAUD_LAST;
                    if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next  = S_PARITY;
                        serial_next = ^shift_reg;
`else
                        state_next  = S_STOP;
                        serial_next = 1'b1;
`endif
                    end else begin
                        bit_next    = bit_inc;
                        serial_next = shift_reg[bit_inc];
                    end
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) begin
                    state_next  = S_STOP;
                    baud_next   = BAUD_LAST;
                    serial_next = 1'b1;
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
`endif

            S_STOP: begin
                // Raise done so it is registered high during the final stop cycle.
                if (baud_reg == BAUD_W'(1)) begin
                    done_next = 1'b1;
                end
                if (baud_last) begin
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        shift_next  = mem[rd_ptr_reg];
                        state_next  = S_START;
                        baud_next   = BAUD_LAST;
                        serial_next = 1'b0;
                        active_next = 1'b1;
                    end else begin
                        state_next  = S_IDLE;
                        serial_next = 1'b1;
                        active_next = 1'b0;
                    end
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end

            default: begin
                state_next  = S_IDLE;
                serial_next = 1'b1;
                active_next = 1'b0;
            end
        endcase
    end

    assign tx_serial = serial_reg;
    assign tx_active = active_reg;
    assign tx_done   = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: bytes are queued at push and checked bit-by-bit as frames leave the line.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int C = 4;
    localparam int D = 87;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_serial, tx_active, tx_done;
    logic [2:0] fifo_count;
    logic [7:0] def_data;
    logic       def_valid;
    logic       def_ready, def_serial, def_active, def_done;
    logic [2:0] def_count;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4), .CNT_W(3)) dut (
        .clk(clk), .reset(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_active(tx_active),
        .tx_done(tx_done), .fifo_count(fifo_count)
    );

    uart_tx dut_def (
        .clk(clk), .reset(rst), .tx_data(def_data), .tx_valid(def_valid),
        .tx_ready(def_ready), .tx_serial(def_serial), .tx_active(def_active),
        .tx_done(def_done), .fifo_count(def_count)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         done_count = 0;
    int         acc_cyc  = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         done_q[$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (tx_done === 1'b1) done_count <= done_count + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] b);
        int k = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("push_timeout", k < 2000, 1);
        exp_q.push_back(b);
        acc_cyc = cyc + 1;
        $display("push byte %02h accepted at cycle %0d", b, acc_cyc);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k = 0;
        while ((exp_q.size() != 0 || tx_active !== 1'b0 || fifo_count !== 3'd0) && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, k < limit, 1);
        repeat (2) @(negedge clk);
    endtask

    // Line monitor: checks every cycle of each frame against the queued byte.
    initial begin : monitor
        logic [10:0] eb, obs;
        logic [7:0]  b;
        int          glitch, done_at, done_hits, act_bad;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx_serial === 1'b0) begin
                check("frame_expected", exp_q.size() != 0, 1);
                b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                eb = frame_bits(b);
                obs = '1;
                start_q.push_back(cyc);
                glitch = 0; done_at = 0; done_hits = 0; act_bad = 0; aborted = 0;
                for (int i = 1; i <= NB * C; i++) begin
                    if (i > 1) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1;
                        break;
                    end
                    if (tx_serial !== eb[(i-1)/C]) glitch++;
                    if ((i - 1) % C == C / 2) obs[(i-1)/C] = tx_serial;
                    if (tx_done === 1'b1) begin
                        done_hits++;
                        done_at = i;
                    end
                    if (tx_active !== 1'b1) act_bad++;
                end
                if (aborted) begin
                    $display("frame %02h abandoned by reset at cycle %0d", b, cyc);
                end else begin
                    $display("frame %02h observed %02h done at frame cycle %0d", b, obs[8:1], done_at);
                    check("frame_byte", obs[8:1], b);
                    check("start_bit", obs[0], 0);
                    check("stop_bit", obs[NB-1], 1);
`ifdef UART_TX_PARITY_EN
                    check("parity_bit", obs[9], ^b);
`endif
                    check("bit_stable", glitch, 0);
                    check("done_pulses", done_hits, 1);
                    check("done_pos", done_at, NB * C);
                    check("active_in_frame", act_bad, 0);
                    done_q.push_back(cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int peak, k, d0, err, hits, done_at, rx_valids, t0;
        logic [10:0] eb, obs;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; def_valid = 1'b0; def_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_serial", tx_serial, 1);
        check("rst_active", tx_active, 0);
        check("rst_done", tx_done, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", tx_ready, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte
        start_q.delete(); done_q.delete();
        d0 = done_count;
        push_byte(8'hA5);
        k = 0;
        while (tx_done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        check("single_done_seen", tx_done, 1);
        @(negedge clk);
        check("single_active_fall", tx_active, 0);
        check("single_idle_high", tx_serial, 1);
        check("single_done_width", tx_done, 0);
        check("single_start_latency", start_q[0] - acc_cyc, 1);
        check("single_done_count", done_count - d0, 1);
        wait_idle("single_idle_timeout", 100);

        // Back-to-back
        start_q.delete(); done_q.delete();
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h3C);
        peak = fifo_count;
        k = 0;
        while (done_q.size() < 3 && k < 400) begin
            @(negedge clk);
            if (fifo_count > peak) peak = fifo_count;
            k++;
        end
        check("b2b_peak_count", peak, 2);
        check("b2b_frames", done_q.size(), 3);
        if (done_q.size() >= 3 && start_q.size() >= 1) begin
            check("b2b_total_cycles", done_q[2] - start_q[0] + 1, 3 * NB * C);
            check("b2b_done_gap1", done_q[1] - done_q[0], NB * C);
            check("b2b_done_gap2", done_q[2] - done_q[1], NB * C);
        end
        wait_idle("b2b_idle_timeout", 200);

        // Full FIFO
        start_q.delete(); done_q.delete();
        push_byte(8'h11);
        @(negedge clk);
        push_byte(8'h21);
        push_byte(8'h32);
        push_byte(8'h43);
        push_byte(8'h54);
        check("full_count", fifo_count, 4);
        check("full_ready_low", tx_ready, 0);
        d0 = done_count;
        push_byte(8'h65);
        check("full_accept_after_pop", done_count - d0, 1);
        check("full_count_after_refill", fifo_count, 4);
        wait_idle("full_drain_timeout", 600);
        check("full_frames", done_q.size(), 6);

        // Reset mid-frame during data bit 3
        start_q.delete(); done_q.delete();
        push_byte(8'h5A);
        push_byte(8'h77);
        k = 0;
        while (start_q.size() < 1 && k < 50) begin @(negedge clk); k++; end
        check("rstmid_frame_started", start_q.size(), 1);
        if (start_q.size() >= 1) begin
            while (cyc < start_q[0] + 4 * C + 1) @(negedge clk);
        end
        #2;
        rst = 1'b1;
        exp_q.delete();
        d0 = done_count;
        #1;
        check("rstmid_serial", tx_serial, 1);
        check("rstmid_active", tx_active, 0);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_ready", tx_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rstmid_no_done", done_count - d0, 0);
        check("rstmid_stays_idle", tx_active, 0);
        start_q.delete(); done_q.delete();
        push_byte(8'h81);
        wait_idle("rstmid_clean_timeout", 100);
        check("rstmid_clean_frames", done_q.size(), 1);

        // Parity-sensitive bytes and frame length
        start_q.delete(); done_q.delete();
        push_byte(8'h07);
        push_byte(8'h03);
        wait_idle("parity_timeout", 200);
        check("parity_frames", done_q.size(), 2);
        if (done_q.size() >= 1 && start_q.size() >= 1)
            check("frame_length", done_q[0] - start_q[0] + 1, NB * C);

        // Default parameter instance, inline receiver
        check("def_ready", def_ready, 1);
        def_data = 8'h55;
        def_valid = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        def_valid = 1'b0;
        def_data = 8'hFF;
        k = 0;
        while (def_serial !== 1'b0 && k < 20) begin @(negedge clk); k++; end
        check("def_start_latency", cyc - t0, 1);
        eb = frame_bits(8'h55);
        obs = '1; err = 0; hits = 0; done_at = 0;
        for (int i = 1; i <= NB * D; i++) begin
            if (i > 1) @(negedge clk);
            if (def_serial !== eb[(i-1)/D]) err++;
            if ((i - 1) % D == D / 2) obs[(i-1)/D] = def_serial;
            if (def_done === 1'b1) begin hits++; done_at = i; end
        end
        rx_valids = (obs[0] == 1'b0 && obs[NB-1] == 1'b1) ? 1 : 0;
        $display("default-param frame rx byte %02h done at cycle %0d", obs[8:1], done_at);
        check("def_bit_hold", err, 0);
        check("def_rx_byte", obs[8:1], 8'h55);
        check("def_done_pos", done_at, NB * D);
        check("def_done_pulses", hits, 1);
        @(negedge clk);
        check("def_active_fall", def_active, 0);
        for (int i = 0; i < 2 * D; i++) begin
            @(negedge clk);
            if (def_serial === 1'b0) begin
                rx_valids++;
                break;
            end
        end
        check("def_rx_valid_pulses", rx_valids, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
